// File: rtl/ahb2axi_cmd_if.sv
// Bus bundle for the AHB-to-AXI command bridge: AHB slave address/response
// signals, the AXI AW/AR command channels and the command FIFO status flags.
interface ahb2axi_cmd_if #(
  parameter int ID_BITS   = 4,
  parameter int ADDR_BITS = 32
);
  // AHB slave side
  logic                 HSEL;
  logic                 HWRITE;
  logic                 HREADY;
  logic [ADDR_BITS-1:0] HADDR;
  logic [1:0]           HTRANS;
  logic [2:0]           HSIZE;
  logic [2:0]           HBURST;
  logic                 HREADYOUT;
  logic                 HRESP;

  // AXI write address channel
  logic                 AWVALID;
  logic                 AWREADY;
  logic [ID_BITS-1:0]   AWID;
  logic [ADDR_BITS-1:0] AWADDR;
  logic [3:0]           AWLEN;
  logic [1:0]           AWSIZE;
  logic [1:0]           AWBURST;

  // AXI read address channel
  logic                 ARVALID;
  logic                 ARREADY;
  logic [ID_BITS-1:0]   ARID;
  logic [ADDR_BITS-1:0] ARADDR;
  logic [3:0]           ARLEN;
  logic [1:0]           ARSIZE;
  logic [1:0]           ARBURST;

  // Command FIFO status
  logic                 cmd_full;
  logic                 cmd_empty;

  // Bridge side: AHB slave, AXI command master
  modport slave (
    input  HSEL, HWRITE, HREADY, HADDR, HTRANS, HSIZE, HBURST,
    output HREADYOUT, HRESP,
    output AWVALID, AWID, AWADDR, AWLEN, AWSIZE, AWBURST,
    input  AWREADY,
    output ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST,
    input  ARREADY,
    output cmd_full, cmd_empty
  );

  // Environment side: AHB master, AXI command slave
  modport master (
    output HSEL, HWRITE, HREADY, HADDR, HTRANS, HSIZE, HBURST,
    input  HREADYOUT, HRESP,
    input  AWVALID, AWID, AWADDR, AWLEN, AWSIZE, AWBURST,
    output AWREADY,
    input  ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST,
    output ARREADY,
    input  cmd_full, cmd_empty
  );
endinterface

// File: rtl/ahb2axi_cmd.sv
// AHB-to-AXI command bridge: captures AHB NONSEQ address phases, rejects
// unsupported bursts and misaligned accesses, and issues the rest in order on AW/AR.
module ahb2axi_cmd #(
  parameter int ID_BITS   = 4,
  parameter int ADDR_BITS = 32,
  parameter int CMD_DEPTH = 2,
  parameter int AXI_ID    = 0
) (
  input logic        clk,
  input logic        reset,
  ahb2axi_cmd_if.slave bus
);

  localparam int                PTR_BITS   = $clog2(CMD_DEPTH);
  localparam logic [PTR_BITS:0] FULL_COUNT = (PTR_BITS + 1)'(CMD_DEPTH);

  typedef enum logic [1:0] {IDLE, PUSH_WAIT, ERR1, ERR2} state_t;

  typedef struct packed {
    logic [ADDR_BITS-1:0] addr;
    logic [3:0]           len;
    logic [1:0]           size;
    logic                 write;
  } cmd_t;

  state_t state_q, state_d;
  cmd_t   pend_q;
  cmd_t   head;
  cmd_t   mem [CMD_DEPTH];

  logic [PTR_BITS-1:0] wr_ptr, rd_ptr;
  logic [PTR_BITS:0]   count;

  logic       accept, take, push, pop;
  logic       burst_ok, misaligned, err;
  logic [3:0] len_map;
  logic       hready_out, hresp;
  logic       full, empty;
  logic       aw_valid, ar_valid;

  // Address-phase decode: burst length mapping and legality of the access
  assign accept = bus.HSEL & bus.HREADY & (bus.HTRANS == 2'b10);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    burst_ok   = 1'b1;
    len_map    = 4'd0;
    misaligned = 1'b0;
    case (bus.HBURST)
      3'b000:  len_map = 4'd0;
      3'b011:  len_map = 4'd3;
      3'b101:  len_map = 4'd7;
      3'b111:  len_map = 4'd15;
      default: burst_ok = 1'b0;
    endcase
    case (bus.HSIZE)
      3'd1:    misaligned = bus.HADDR[0];
      3'd2:    misaligned = |bus.HADDR[1:0];
      3'd3:    misaligned = |bus.HADDR[2:0];
      default: misaligned = 1'b0;
    endcase
    err = ~burst_ok | bus.HSIZE[2] | misaligned;
  end

  // Control FSM
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    hready_out = 1'b1;
    hresp      = 1'b0;
    take       = 1'b0;
    push       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          take    = 1'b1;
          state_d = err ? ERR1 : PUSH_WAIT;
        end
      end
      PUSH_WAIT: begin
        if (full) begin
          hready_out = 1'b0;
        end else begin
          push = 1'b1;
          if (accept) begin
            take    = 1'b1;
            state_d = err ? ERR1 : PUSH_WAIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      ERR1: begin
        hready_out = 1'b0;
        hresp      = 1'b1;
        state_d    = ERR2;
      end
      ERR2: begin
        hresp = 1'b1;
        if (accept) begin
          take    = 1'b1;
          state_d = err ? ERR1 : PUSH_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pending command captured from the accepted address phase
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
    end else if (take) begin
      pend_q <= '{addr: bus.HADDR, len: len_map, size: bus.HSIZE[1:0], write: bus.HWRITE};
    end
  end

  // Command FIFO shared by both channels to keep AHB acceptance order
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the occupancy count decides what is visible.
    if (push) mem[wr_ptr] <= pend_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_BITS + 1)'(1);
        2'b01:   count <= count - (PTR_BITS + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Head steers to exactly one channel; it stays put until that channel handshakes
  assign aw_valid = ~empty &  head.write;
  assign ar_valid = ~empty & ~head.write;
  assign pop      = (aw_valid & bus.AWREADY) | (ar_valid & bus.ARREADY);

  assign bus.HREADYOUT = hready_out;
  assign bus.HRESP     = hresp;
  assign bus.cmd_full  = full;
  assign bus.cmd_empty = empty;

  assign bus.AWVALID = aw_valid;
  assign bus.AWID    = ID_BITS'(AXI_ID);
  assign bus.AWADDR  = head.addr;
  assign bus.AWLEN   = head.len;
  assign bus.AWSIZE  = head.size;
  assign bus.AWBURST = 2'b01;

  assign bus.ARVALID = ar_valid;
  assign bus.ARID    = ID_BITS'(AXI_ID);
  assign bus.ARADDR  = head.addr;
  assign bus.ARLEN   = head.len;
  assign bus.ARSIZE  = head.size;
  assign bus.ARBURST = 2'b01;

endmodule

// File: tb/tb_ahb2axi_cmd.sv
// Directed bench for ahb2axi_cmd: single-master AHB system (HREADY = HREADYOUT)
// with hand-computed expectations for each scenario.
module tb_ahb2axi_cmd;
  localparam int ID_BITS   = 4;
  localparam int ADDR_BITS = 32;
  localparam int CMD_DEPTH = 2;
  localparam int AXI_ID    = 0;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  ahb2axi_cmd_if #(.ID_BITS(ID_BITS), .ADDR_BITS(ADDR_BITS)) bus ();

  ahb2axi_cmd #(
    .ID_BITS(ID_BITS), .ADDR_BITS(ADDR_BITS), .CMD_DEPTH(CMD_DEPTH), .AXI_ID(AXI_ID)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  // Only slave on the bus, so the global ready is its own ready
  assign bus.HREADY = bus.HREADYOUT;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic        err;
    logic [3:0]  len;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nonseq(input logic [31:0] addr, input logic write,
                              input logic [2:0] size, input logic [2:0] burst);
    bus.HSEL   = 1'b1;
    bus.HTRANS = 2'b10;
    bus.HADDR  = addr;
    bus.HWRITE = write;
    bus.HSIZE  = size;
    bus.HBURST = burst;
  endtask

  task automatic drive_idle();
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
    bus.HADDR  = '0;
    bus.HWRITE = 1'b0;
    bus.HSIZE  = 3'd0;
    bus.HBURST = 3'b000;
  endtask

  // One address phase; returns in the cycle after capture
  task automatic single(input logic [31:0] addr, input logic write,
                        input logic [2:0] size, input logic [2:0] burst);
    drive_nonseq(addr, write, size, burst);
    tick();
    drive_idle();
  endtask

  // {AWVALID, ARVALID, HREADYOUT, HRESP, cmd_empty, cmd_full}
  function automatic logic [5:0] flags();
    return {bus.AWVALID, bus.ARVALID, bus.HREADYOUT, bus.HRESP, bus.cmd_empty, bus.cmd_full};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    bus.AWREADY = 1'b0;
    bus.ARREADY = 1'b0;
    tick();
    tick();
    total++;
    if (flags() !== 6'b001010) begin
      bad++; $display("FAIL reset_hold: flags got %b want %b", flags(), 6'b001010);
    end
    reset = 1'b0;
    tick();
    total++;
    if (flags() !== 6'b001010) begin
      bad++; $display("FAIL reset_release: flags got %b want %b", flags(), 6'b001010);
    end
  endtask

  task automatic test_single_read();
    bus.ARREADY = 1'b1;
    single(32'h100, 1'b0, 3'd2, 3'b000);
    total++;
    if ({bus.ARVALID, bus.AWVALID, bus.cmd_empty} !== 3'b001) begin
      bad++; $display("FAIL read_t1: {arv,awv,empty} got %b want 001",
                      {bus.ARVALID, bus.AWVALID, bus.cmd_empty});
    end
    tick();
    total++;
    if ({bus.ARVALID, bus.AWVALID, bus.ARADDR, bus.ARLEN, bus.ARSIZE, bus.ARBURST, bus.ARID}
        !== {1'b1, 1'b0, 32'h100, 4'd0, 2'd2, 2'b01, 4'(AXI_ID)}) begin
      bad++; $display("FAIL read_t2: arv=%b awv=%b addr=%h len=%0d size=%0d burst=%b id=%0d want 1 0 100 0 2 01 %0d",
                      bus.ARVALID, bus.AWVALID, bus.ARADDR, bus.ARLEN, bus.ARSIZE, bus.ARBURST, bus.ARID, AXI_ID);
    end
    tick();
    total++;
    if ({bus.ARVALID, bus.cmd_empty} !== 2'b01) begin
      bad++; $display("FAIL read_t3: {arv,empty} got %b want 01", {bus.ARVALID, bus.cmd_empty});
    end
    bus.ARREADY = 1'b0;
  endtask

  task automatic test_write_stall();
    bus.AWREADY = 1'b0;
    single(32'h2000, 1'b1, 3'd2, 3'b101);
    tick();
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({bus.AWVALID, bus.ARVALID, bus.AWADDR, bus.AWLEN, bus.AWSIZE, bus.AWBURST}
          !== {1'b1, 1'b0, 32'h2000, 4'd7, 2'd2, 2'b01}) begin
        bad++; $display("FAIL write_hold[%0d]: awv=%b arv=%b addr=%h len=%0d size=%0d burst=%b want 1 0 2000 7 2 01",
                        i, bus.AWVALID, bus.ARVALID, bus.AWADDR, bus.AWLEN, bus.AWSIZE, bus.AWBURST);
      end
      tick();
    end
    bus.AWREADY = 1'b1;
    tick();
    bus.AWREADY = 1'b0;
    total++;
    if ({bus.AWVALID, bus.cmd_empty} !== 2'b01) begin
      bad++; $display("FAIL write_drop: {awv,empty} got %b want 01", {bus.AWVALID, bus.cmd_empty});
    end
  endtask

  task automatic test_misaligned();
    single(32'h102, 1'b0, 3'd2, 3'b000);
    total++;
    if (flags() !== 6'b000110) begin
      bad++; $display("FAIL misalign_err1: flags got %b want 000110", flags());
    end
    tick();
    total++;
    if (flags() !== 6'b001110) begin
      bad++; $display("FAIL misalign_err2: flags got %b want 001110", flags());
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (flags() !== 6'b001010) begin
        bad++; $display("FAIL misalign_after[%0d]: flags got %b want 001010", i, flags());
      end
    end
  endtask

  task automatic test_wrap4();
    bus.AWREADY = 1'b0;
    single(32'h800, 1'b1, 3'd2, 3'b000);
    tick();
    single(32'h900, 1'b0, 3'd2, 3'b010);
    total++;
    if (flags() !== 6'b100100) begin
      bad++; $display("FAIL wrap4_err1: flags got %b want 100100", flags());
    end
    tick();
    total++;
    if (flags() !== 6'b101100) begin
      bad++; $display("FAIL wrap4_err2: flags got %b want 101100", flags());
    end
    tick();
    total++;
    if ({flags(), bus.AWADDR} !== {6'b101000, 32'h800}) begin
      bad++; $display("FAIL wrap4_occupancy: flags=%b addr=%h want 101000 800", flags(), bus.AWADDR);
    end
    bus.AWREADY = 1'b1;
    tick();
    bus.AWREADY = 1'b0;
    total++;
    if (flags() !== 6'b001010) begin
      bad++; $display("FAIL wrap4_drain: flags got %b want 001010", flags());
    end
  endtask

  task automatic test_err_cases();
    vec_t v [7];
    v = '{
      '{addr: 32'h104, size: 3'd2, burst: 3'b011, err: 1'b0, len: 4'd3},
      '{addr: 32'h101, size: 3'd0, burst: 3'b111, err: 1'b0, len: 4'd15},
      '{addr: 32'h101, size: 3'd1, burst: 3'b000, err: 1'b1, len: 4'd0},
      '{addr: 32'h104, size: 3'd3, burst: 3'b000, err: 1'b1, len: 4'd0},
      '{addr: 32'h108, size: 3'd3, burst: 3'b101, err: 1'b0, len: 4'd7},
      '{addr: 32'h100, size: 3'd4, burst: 3'b000, err: 1'b1, len: 4'd0},
      '{addr: 32'h100, size: 3'd2, burst: 3'b001, err: 1'b1, len: 4'd0}
    };
    bus.ARREADY = 1'b1;
    for (int i = 0; i < 7; i++) begin
      single(v[i].addr, 1'b0, v[i].size, v[i].burst);
      total++;
      if ({bus.HRESP, bus.HREADYOUT} !== {v[i].err, ~v[i].err}) begin
        bad++; $display("FAIL case_t1[%0d]: {hresp,hreadyout} got %b want %b",
                        i, {bus.HRESP, bus.HREADYOUT}, {v[i].err, ~v[i].err});
      end
      tick();
      total++;
      if (v[i].err) begin
        if ({bus.HRESP, bus.HREADYOUT, bus.ARVALID} !== 3'b110) begin
          bad++; $display("FAIL case_t2[%0d]: {hresp,hreadyout,arv} got %b want 110",
                          i, {bus.HRESP, bus.HREADYOUT, bus.ARVALID});
        end
      end else begin
        if ({bus.ARVALID, bus.ARLEN, bus.ARADDR, bus.ARSIZE} !== {1'b1, v[i].len, v[i].addr, v[i].size[1:0]}) begin
          bad++; $display("FAIL case_t2[%0d]: arv=%b len=%0d addr=%h size=%0d want 1 %0d %h %0d",
                          i, bus.ARVALID, bus.ARLEN, bus.ARADDR, bus.ARSIZE, v[i].len, v[i].addr, v[i].size);
        end
      end
      tick();
      total++;
      if (flags() !== 6'b001010) begin
        bad++; $display("FAIL case_t3[%0d]: flags got %b want 001010", i, flags());
      end
    end
    bus.ARREADY = 1'b0;
  endtask

  task automatic test_full();
    bus.AWREADY = 1'b0;
    drive_nonseq(32'h000, 1'b1, 3'd2, 3'b000);
    tick();
    drive_nonseq(32'h010, 1'b1, 3'd2, 3'b000);
    tick();
    drive_nonseq(32'h020, 1'b1, 3'd2, 3'b000);
    tick();
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({flags(), bus.AWADDR} !== {6'b100001, 32'h000}) begin
        bad++; $display("FAIL full_stall[%0d]: flags=%b addr=%h want 100001 0", i, flags(), bus.AWADDR);
      end
      tick();
    end
    bus.AWREADY = 1'b1;
    total++;
    if (flags() !== 6'b100001) begin
      bad++; $display("FAIL full_pop_cycle: flags got %b want 100001", flags());
    end
    tick();
    bus.AWREADY = 1'b0;
    total++;
    if ({flags(), bus.AWADDR} !== {6'b101000, 32'h010}) begin
      bad++; $display("FAIL full_push: flags=%b addr=%h want 101000 10", flags(), bus.AWADDR);
    end
    tick();
    total++;
    if ({flags(), bus.AWADDR} !== {6'b101001, 32'h010}) begin
      bad++; $display("FAIL full_refill: flags=%b addr=%h want 101001 10", flags(), bus.AWADDR);
    end
    bus.AWREADY = 1'b1;
    tick();
    total++;
    if ({flags(), bus.AWADDR} !== {6'b101000, 32'h020}) begin
      bad++; $display("FAIL full_third: flags=%b addr=%h want 101000 20", flags(), bus.AWADDR);
    end
    tick();
    bus.AWREADY = 1'b0;
    total++;
    if (flags() !== 6'b001010) begin
      bad++; $display("FAIL full_drain: flags got %b want 001010", flags());
    end
  endtask

  task automatic test_back_to_back_order();
    bus.AWREADY = 1'b0;
    bus.ARREADY = 1'b1;
    drive_nonseq(32'h300, 1'b1, 3'd2, 3'b000);
    tick();
    drive_nonseq(32'h400, 1'b0, 3'd2, 3'b000);
    tick();
    drive_idle();
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({bus.AWVALID, bus.ARVALID, bus.AWADDR} !== {1'b1, 1'b0, 32'h300}) begin
        bad++; $display("FAIL order_block[%0d]: awv=%b arv=%b addr=%h want 1 0 300",
                        i, bus.AWVALID, bus.ARVALID, bus.AWADDR);
      end
      tick();
    end
    bus.AWREADY = 1'b1;
    tick();
    bus.AWREADY = 1'b0;
    total++;
    if ({bus.AWVALID, bus.ARVALID, bus.ARADDR, bus.ARLEN} !== {1'b0, 1'b1, 32'h400, 4'd0}) begin
      bad++; $display("FAIL order_read: awv=%b arv=%b addr=%h len=%0d want 0 1 400 0",
                      bus.AWVALID, bus.ARVALID, bus.ARADDR, bus.ARLEN);
    end
    tick();
    total++;
    if (flags() !== 6'b001010) begin
      bad++; $display("FAIL order_drain: flags got %b want 001010", flags());
    end
    bus.ARREADY = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.AWREADY = 1'b0;
    bus.ARREADY = 1'b0;
    drive_nonseq(32'h500, 1'b1, 3'd2, 3'b000);
    tick();
    drive_nonseq(32'h600, 1'b0, 3'd2, 3'b000);
    tick();
    drive_nonseq(32'h700, 1'b1, 3'd2, 3'b000);
    tick();
    drive_idle();
    total++;
    if (flags() !== 6'b100001) begin
      bad++; $display("FAIL rmid_before: flags got %b want 100001", flags());
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (flags() !== 6'b001010) begin
      bad++; $display("FAIL rmid_after: flags got %b want 001010", flags());
    end
    bus.AWREADY = 1'b1;
    bus.ARREADY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (flags() !== 6'b001010) begin
        bad++; $display("FAIL rmid_stale[%0d]: flags got %b want 001010", i, flags());
      end
    end
    single(32'h103, 1'b1, 3'd2, 3'b000);
    total++;
    if (flags() !== 6'b000110) begin
      bad++; $display("FAIL rerr_err1: flags got %b want 000110", flags());
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (flags() !== 6'b001010) begin
      bad++; $display("FAIL rerr_after: flags got %b want 001010", flags());
    end
    tick();
    total++;
    if (flags() !== 6'b001010) begin
      bad++; $display("FAIL rerr_settle: flags got %b want 001010", flags());
    end
    bus.AWREADY = 1'b0;
    bus.ARREADY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_read();
    test_write_stall();
    test_misaligned();
    test_wrap4();
    test_err_cases();
    test_full();
    test_back_to_back_order();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb2axi_cmd.md
AHB2AXI_CMD -- requirements
Module: ahb2axi_cmd

Interface
REQ-001 Parameter: ID_BITS, default 4, width of AXI ID fields.
REQ-002 Parameter: ADDR_BITS, default 32, width of AHB and AXI address.
REQ-003 Parameter: CMD_DEPTH, default 2, command FIFO depth in entries (power of 2, at least 2).
REQ-004 Parameter: AXI_ID, default 0, constant driven on AWID/ARID.
REQ-005 Port: clk  input  1  single clock; all logic rising-edge.
REQ-006 Port: reset  input  1  synchronous, active-high reset.
REQ-007 Ports: HSEL, HWRITE, HREADY  input  1 each  AHB slave select, direction, global ready.
REQ-008 Ports: HADDR  input  ADDR_BITS; HTRANS  input  2; HSIZE  input  3; HBURST  input  3.
REQ-009 Ports: HREADYOUT, HRESP  output  1 each  slave ready and error response.
REQ-010 Ports: AWVALID  output  1; AWREADY  input  1; AWID  output  ID_BITS; AWADDR  output  ADDR_BITS; AWLEN  output  4; AWSIZE  output  2; AWBURST  output  2.
REQ-011 Ports: ARVALID, ARREADY, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, with the same directions and widths as the AW ports.
REQ-012 Ports: cmd_full, cmd_empty  output  1 each  FIFO status.

Function
REQ-013 Accept: an address phase is captured when HSEL & HREADY & HTRANS==2'b10 (NONSEQ); SEQ, BUSY and IDLE are never captured.
REQ-014 Capture register: on accept, store HADDR, HWRITE, HSIZE[1:0] and the mapped length into a pending register.
REQ-015 Length map: HBURST 000 maps to 0, 011 to 3, 101 to 7, 111 to 15.
REQ-016 Error: err is set for any other HBURST, for HSIZE>3, or for an address misaligned to HSIZE (bit0 for size 1, bits[1:0] for size 2, bits[2:0] for size 3).
REQ-017 FSM: states IDLE, PUSH_WAIT, ERR1, ERR2; the reset state is IDLE.
REQ-018 IDLE: an accept without err moves to PUSH_WAIT; an accept with err moves to ERR1; otherwise the FSM stays in IDLE.
REQ-019 PUSH_WAIT: if cmd_full==0, push the pending command and return to IDLE, or re-enter PUSH_WAIT if a new accept occurs in the same cycle.
REQ-020 PUSH_WAIT full: if cmd_full==1, HREADYOUT=0 and the FSM stays in PUSH_WAIT.
REQ-021 Push/pop: push is blocked when full even if a pop occurs in the same cycle; simultaneous push and pop on a non-full FIFO keep the occupancy unchanged.
REQ-022 ERR1: HREADYOUT=0 and HRESP=1; the next state is ERR2.
REQ-023 ERR2: HREADYOUT=1 and HRESP=1; the next state is IDLE; an erroneous command is never pushed.
REQ-024 ERR2 accept: an accept that occurs in ERR2 is treated as a new accept, exactly as from IDLE.
REQ-025 Default ready: HREADYOUT=1 and HRESP=0 in IDLE, and in PUSH_WAIT while not full.
REQ-026 FIFO entry: the entry is {addr, len, size, write}, width ADDR_BITS+7.
REQ-027 Read pop: when the FIFO head has write=0, ARVALID=~cmd_empty and AWVALID=0; pop on ARVALID&ARREADY.
REQ-028 Write pop: when the FIFO head has write=1, AWVALID=~cmd_empty and ARVALID=0; pop on AWVALID&AWREADY.
REQ-029 VALID stability: once VALID is asserted, VALID and all fields hold stable until READY; READY is ignored while VALID=0.
REQ-030 Outputs: AxID=AXI_ID, AxBURST=2'b01 (INCR), AxLEN=len and AxSIZE=size from the FIFO head, on both channels.
REQ-031 Latency: a NONSEQ accepted at cycle T with the FIFO not full pushes at T+1, and AxVALID rises at T+2.
REQ-032 Ordering: commands issue strictly in AHB acceptance order across both channels; a stalled AW head blocks a following AR command, and vice versa.

Reset
REQ-033 Reset: when reset=1 at a clock edge, the FSM goes to IDLE, the FIFO empties and the pending register clears.
REQ-034 Reset outputs: from the next cycle, AWVALID=0, ARVALID=0, HREADYOUT=1, HRESP=0, cmd_empty=1 and cmd_full=0.
REQ-035 Reset mid-operation: a reset during PUSH_WAIT, ERR1 or ERR2, or while VALID is high, discards every command without a handshake.

Verification
REQ-036 Single read: NONSEQ HWRITE=0, HADDR=0x100, HSIZE=2, HBURST=000, ARREADY=1 -> ARVALID high for 1 cycle at T+2 with ARADDR=0x100, ARLEN=0, ARSIZE=2, ARBURST=01.
REQ-037 INCR8 write with AWREADY=0 for 5 cycles -> AWVALID held high with AWLEN=7 constant, and it drops in the cycle after the AWREADY pulse.
REQ-038 Misaligned HADDR=0x102 with HSIZE=2 -> HRESP high for 2 cycles (HREADYOUT 0 then 1), and no AWVALID or ARVALID ever.
REQ-039 HBURST=010 (WRAP4) -> the same two-cycle error, and FIFO occupancy is unchanged.
REQ-040 CMD_DEPTH=2 with AWREADY=0 and 3 NONSEQ writes -> cmd_full=1 and HREADYOUT=0 on the third write until one AWREADY pulse, then the third write is pushed.
REQ-041 Alternating W/R/W commands with 2 queued and reset asserted for 1 cycle -> VALIDs drop, cmd_empty=1, and no stale command issues afterwards.
